alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
// Shares one NBITS-wide registered ALU (3-bit opcode, 1-cycle registered outputs
// result/carryout/overflow/zero) between two requesters. Round-robin arbitration,
// valid/ready handshake per requester, one op in flight, tagged response port.
// Sits between requesting units and the ALU instance; drives ALU inputs directly.
// PARAMETERS
// NBITS  4  operand/result width; must match the ALU instance
// PORTS
// clk          in   1        rising-edge clock
// reset_n      in   1        asynchronous, active-low reset
// req_valid    in   2        per-requester request valid (bit i = requester i)
// req_ready    out  2        per-requester accept; at most one bit high
// req0_a/req0_b in  NBITS    requester 0 operands
// req0_op      in   3        requester 0 opcode
// req1_a/req1_b in  NBITS    requester 1 operands
// req1_op      in   3        requester 1 opcode
// alu_a/alu_b  out  NBITS    to ALU A/B (registered)
// alu_op       out  3        to ALU opcode (registered)
// alu_result   in   NBITS    from ALU result
// alu_cout/alu_ovf/alu_zero in 1  from ALU flags
// rsp_valid    out  1        response valid
// rsp_ready    in   1        response consumer ready
// rsp_id       out  1        requester that issued this op
// rsp_result   out  NBITS    captured result
// rsp_cout/rsp_ovf/rsp_zero out 1  captured flags
// busy         out  1        high in any state except IDLE
// BEHAVIOUR
// - Reset (reset_n low, async): state=IDLE; alu_a/alu_b=0, alu_op=3'b000; rsp_valid=0,
//   rsp_id=0, rsp_result=0, flags=0; rr_last=1 (requester 0 wins first tie); busy=0.
// - FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE. No other transitions.
// - IDLE: req_ready combinational: if one valid, that bit high; if both, grant the
//   requester != rr_last. Handshake = req_valid[i] & req_ready[i]. On handshake edge:
//   latch that requester's a/b/op into alu_a/alu_b/alu_op, latch id, rr_last<=id, ->ISSUE.
//   No valid: stay IDLE, req_ready=0.
// - ISSUE: one cycle; ALU samples alu_* at the closing edge. -> CAPTURE.
// - CAPTURE: one cycle; at closing edge latch alu_result/flags into rsp_*; rsp_valid<=1; ->RESP.
// - RESP: rsp_valid held, all rsp_* stable until rsp_valid & rsp_ready edge; then
//   rsp_valid<=0, ->IDLE. A new request is accepted no earlier than the following cycle.
// - req_ready=2'b00 in every state except IDLE; requests wait, never dropped.
// - Latency: accept edge to rsp_valid high = 2 edges; min issue interval = 4 cycles
//   with rsp_ready tied high.
// - alu_a/alu_b/alu_op hold their last value outside the accept edge.
// - No arithmetic here; widths pass through unchanged. rsp_id is 1 bit, no wrap issue.
// - rr_last updates only on accept; lone requester is granted regardless of rr_last.
// - Reset mid-operation: in-flight op discarded, no response emitted, outputs to reset values.
// TESTING
// 1 Reset: reset_n low mid-RESP -> rsp_valid=0, req_ready=0, busy=0, alu_op=000 immediately.
// 2 Single req0 a=7 b=1 op=001, rsp_ready=1 -> rsp_valid 2 edges after accept,
//   rsp_id=0, rsp_result=4'b1000, rsp_ovf=1, rsp_zero=0.
// 3 Both valid every cycle after reset, rsp_ready=1 -> grants 0,1,0,1; each rsp_id matches order.
// 4 req1 a=3 b=3 op=110 with rsp_ready=0 for 5 cycles -> rsp_valid held, result=0 zero=1
//   stable; req_ready stays 00 until ready then IDLE.
// 5 req0 a=15 b=1 op=000 -> rsp_result=0, rsp_cout=1; req1 op=010 a=2 b=3 next -> result=4'hF.
// 6 req_valid dropped in IDLE before grant -> no ALU update, alu_* unchanged, busy=0.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: two request ports, the ALU drive/return
// signals and the tagged response port. The arbiter uses the slave view;
// requesters, ALU and response consumer together form the master view.
interface alu_req_arbiter_if #(
  parameter int unsigned NBITS = 4
);
  // request side
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [NBITS-1:0] req0_a;
  logic [NBITS-1:0] req0_b;
  logic [2:0]       req0_op;
  logic [NBITS-1:0] req1_a;
  logic [NBITS-1:0] req1_b;
  logic [2:0]       req1_op;

  // ALU side
  logic [NBITS-1:0] alu_a;
  logic [NBITS-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [NBITS-1:0] alu_result;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_zero;

  // response side
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [NBITS-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             rsp_zero;

  // status
  logic             busy;

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  alu_result, alu_cout, alu_ovf, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf, rsp_zero,
    output busy
  );

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output alu_result, alu_cout, alu_ovf, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf, rsp_zero,
    input  busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single registered ALU.
// One operation in flight: IDLE accepts, ISSUE lets the ALU sample its
// operands, CAPTURE latches the ALU outputs, RESP holds the tagged response
// until the consumer takes it.
module alu_req_arbiter #(
  parameter int unsigned NBITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e           state_q,      state_d;
  logic             rr_last_q,    rr_last_d;
  logic [NBITS-1:0] alu_a_q,      alu_a_d;
  logic [NBITS-1:0] alu_b_q,      alu_b_d;
  logic [2:0]       alu_op_q,     alu_op_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_id_q,     rsp_id_d;
  logic [NBITS-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q,   rsp_cout_d;
  logic             rsp_ovf_q,    rsp_ovf_d;
  logic             rsp_zero_q,   rsp_zero_d;
  logic             busy_q,       busy_d;

  logic             grant_vld;
  logic             grant_id;
  logic [1:0]       req_ready;
  logic             accept;

  // Arbitration: a lone requester always wins; on a tie the requester that
  // did not win last time is picked.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = ~rr_last_q;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  // Ready is offered only in IDLE and only to the granted requester; it is
  // also forced low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (reset_n && (state_q == S_IDLE) && grant_vld) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(bus.req_valid & req_ready);

  // Next-state and next-output computation; everything holds by default.
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d   = grant_id ? bus.req1_a  : bus.req0_a;
          alu_b_d   = grant_id ? bus.req1_b  : bus.req0_b;
          alu_op_d  = grant_id ? bus.req1_op : bus.req0_op;
          rr_last_d = grant_id;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // rr_last only moves on accept, so it still names the in-flight requester
        rsp_id_d     = rr_last_q;
        rsp_result_d = bus.alu_result;
        rsp_cout_d   = bus.alu_cout;
        rsp_ovf_d    = bus.alu_ovf;
        rsp_zero_d   = bus.alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_last_q    <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = busy_q;

  // At most one requester is ever offered ready.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));

  // Ready is never offered while an operation is in flight.
  a_ready_idle_only: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q != S_IDLE) |-> (req_ready == 2'b00));

endmodule
